// File: rtl/cdb_arbiter.sv
// Round-robin writeback arbiter driving the registered common data bus; drops
// wrong-path results younger than a broadcast mispredict. Define
// CDB_ARB_BRANCH_PRIO_EN to give mispredicting branches grant precedence.
module cdb_arbiter #(
  parameter int unsigned NUM_FU     = 3,
  parameter int unsigned ROB_WIDTH  = 4,
  parameter int unsigned PREG_WIDTH = 7
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_FU-1:0]               i_req_valid,
  input  logic [NUM_FU*ROB_WIDTH-1:0]     i_req_tag,
  input  logic [NUM_FU*PREG_WIDTH-1:0]    i_req_preg,
  input  logic [NUM_FU*32-1:0]            i_req_data,
  input  logic [NUM_FU-1:0]               i_req_mispredict,
  output logic [NUM_FU-1:0]               o_req_ready,
  input  logic [ROB_WIDTH-1:0]            i_rob_head,
  output logic                            o_cdb_valid,
  output logic [ROB_WIDTH-1:0]            o_cdb_tag,
  output logic [PREG_WIDTH-1:0]           o_cdb_preg,
  output logic [31:0]                     o_cdb_data,
  output logic                            o_cdb_mispredict
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned PTR_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic                  cdb_valid_q, cdb_valid_d;
  logic [ROB_WIDTH-1:0]  cdb_tag_q, cdb_tag_d;
  logic [PREG_WIDTH-1:0] cdb_preg_q, cdb_preg_d;
  logic [DATA_W-1:0]     cdb_data_q, cdb_data_d;
  logic                  cdb_mis_q, cdb_mis_d;

  logic [ROB_WIDTH-1:0]  req_age [NUM_FU];
  logic [ROB_WIDTH-1:0]  bcast_age;
  logic                  squash_en;
  logic [NUM_FU-1:0]     squash;
  logic [NUM_FU-1:0]     eligible;
  logic [NUM_FU-1:0]     pool;
  logic [NUM_FU-1:0]     grant;
  logic [PTR_W-1:0]      cand;
  logic [PTR_W-1:0]      win_idx;
  logic                  win_found;

  // Modular age relative to the ROB head; wrong-path results are strictly younger.
  always_comb begin
    squash_en = cdb_valid_q & cdb_mis_q;
    bcast_age = cdb_tag_q - i_rob_head;
    squash    = '0;
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      req_age[i] = i_req_tag[i*ROB_WIDTH +: ROB_WIDTH] - i_rob_head;
      squash[i]  = squash_en & i_req_valid[i] & (req_age[i] > bcast_age);
    end
  end

  // Candidate pool: branch mispredicts first when prioritisation is enabled.
  always_comb begin
    eligible = i_req_valid & ~squash;
`ifdef CDB_ARB_BRANCH_PRIO_EN
    pool = ((eligible & i_req_mispredict) != '0) ? (eligible & i_req_mispredict) : eligible;
`else
    pool = eligible;
`endif
  end

  // First pool member at or after rr_ptr, with wrap.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_FU; k++) begin
      cand = PTR_W'((32'(rr_ptr_q) + k) % NUM_FU);
      if (!win_found && pool[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    grant = '0;
    if (win_found && !reset) begin
      grant[win_idx] = 1'b1;
    end
    o_req_ready = reset ? '0 : (grant | squash);
  end

  // Next-state: pointer advances past the winner; payload holds when idle.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    cdb_valid_d = |grant;
    cdb_tag_d   = cdb_tag_q;
    cdb_preg_d  = cdb_preg_q;
    cdb_data_d  = cdb_data_q;
    cdb_mis_d   = cdb_mis_q;
    if (|grant) begin
      rr_ptr_d   = (win_idx == PTR_W'(NUM_FU - 1)) ? '0 : win_idx + PTR_W'(1);
      cdb_tag_d  = i_req_tag[win_idx*ROB_WIDTH +: ROB_WIDTH];
      cdb_preg_d = i_req_preg[win_idx*PREG_WIDTH +: PREG_WIDTH];
      cdb_data_d = i_req_data[win_idx*DATA_W +: DATA_W];
      cdb_mis_d  = i_req_mispredict[win_idx];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q    <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_preg_q  <= '0;
      cdb_data_q  <= '0;
      cdb_mis_q   <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_preg_q  <= cdb_preg_d;
      cdb_data_q  <= cdb_data_d;
      cdb_mis_q   <= cdb_mis_d;
    end
  end

  assign o_cdb_valid      = cdb_valid_q;
  assign o_cdb_tag        = cdb_tag_q;
  assign o_cdb_preg       = cdb_preg_q;
  assign o_cdb_data       = cdb_data_q;
  assign o_cdb_mispredict = cdb_mis_q;

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Writeback arbiter sharing the single common data bus (CDB) among NUM_FU functional units. Each cycle it grants at most one pending result by round-robin and registers it onto the CDB. The CDB feeds the ROB busy-clear path and its branch_mispredict input. When the registered CDB result carries a misprediction, the arbiter silently drops pending results from instructions younger than the mispredicting branch, so wrong-path results never reach the bus.

## Interface
- NUM_FU, 3, number of requesting functional units (≥2)
- ROB_WIDTH, 4, ROB tag width; ROB_SIZE = 2^ROB_WIDTH
- PREG_WIDTH, 7, physical register tag width
- clk  in  1  clock; all state updates on posedge
- reset  in  1  asynchronous, active-high; clears all state immediately
- i_req_valid  in  NUM_FU  per-FU result pending
- i_req_tag  in  NUM_FU*ROB_WIDTH  per-FU ROB tag; FU i occupies bits [i*ROB_WIDTH +: ROB_WIDTH]
- i_req_preg  in  NUM_FU*PREG_WIDTH  per-FU destination preg
- i_req_data  in  NUM_FU*32  per-FU result value
- i_req_mispredict  in  NUM_FU  per-FU result is a mispredicted branch
- o_req_ready  out  NUM_FU  per-FU request consumed this cycle (granted or squashed)
- i_rob_head  in  ROB_WIDTH  current ROB head pointer, used for age comparison
- o_cdb_valid  out  1  CDB broadcast valid
- o_cdb_tag  out  ROB_WIDTH  broadcast ROB tag
- o_cdb_preg  out  PREG_WIDTH  broadcast preg
- o_cdb_data  out  32  broadcast value
- o_cdb_mispredict  out  1  broadcast is a mispredicting branch

## Operation
- Handshake: FU i holds valid and payload stable until o_req_ready[i]=1. A request is consumed in any cycle where valid and ready are both high. o_req_ready is combinational from the current inputs and state.
- Age: age(x) = (x − i_rob_head) mod ROB_SIZE, computed in ROB_WIDTH bits.
- Squash: active when o_cdb_valid && o_cdb_mispredict.
  - A valid request with age(tag) > age(o_cdb_tag) is squashed: ready=1, it is not broadcast, and rr_ptr is unchanged.
  - Requests not younger than the broadcast branch arbitrate normally.
- Eligible set: valid and not squashed.
- Round-robin: state rr_ptr in [0, NUM_FU−1].
  - Grant goes to the first eligible index scanning rr_ptr, rr_ptr+1, … with wrap.
  - After a grant to index g, rr_ptr <= (g+1) mod NUM_FU.
  - With no grant, rr_ptr holds.
- ready[i] = grant[i] | squash[i]. Grant is one-hot or zero.
- Output register: on posedge, o_cdb_valid <= |grant. If granted, the payload registers load the winner's fields. If not granted, the payload registers hold their value; consumers ignore payload when o_cdb_valid=0.
- No backpressure from the CDB; the ROB always accepts a broadcast.

## Timing
- Reset (asynchronous): o_cdb_valid, o_cdb_tag, o_cdb_preg, o_cdb_data, o_cdb_mispredict = 0; rr_ptr = 0. During reset o_req_ready = 0.
- Reset mid-operation: an in-flight broadcast is lost. Requesters keep their valid asserted and re-arbitrate after reset deassertion.
- Latency: request granted in cycle t appears on the CDB in cycle t+1. Throughput is one result per cycle.
- A FU holding valid continuously with new payload after each ready gets back-to-back grants if it is the only requester.
- Squash window: exactly the cycle the mispredict is on the CDB. Requests arriving later are not squashed here; upstream flush handles them.
- Back-to-back mispredicts: a younger mispredict is squashed. An older one is granted normally and broadcast the next cycle.
- Equal tag to the broadcast branch (age equal): not squashed.
- Wrap-around: the age math is modular, so a head near ROB_SIZE−1 with tags wrapped to 0.. compares correctly.

## Configuration
- CDB_ARB_BRANCH_PRIO_EN defined:
  - Eligible requests with i_req_mispredict=1 take precedence.
  - Round-robin from rr_ptr applies among them.
  - Only if none exist does round-robin apply over all eligible requests.
  - The rr_ptr update rule is unchanged.
- Undefined: pure round-robin; the mispredict bit does not affect grant order.

## Test plan
- Assert reset asynchronously between edges while o_cdb_valid=1 → all outputs 0 immediately, before the next posedge; rr_ptr=0 afterwards.
- NUM_FU=3; FU0/1/2 valid with tags 1/2/3, each FU drops valid after its ready → grants FU0, FU1, FU2 in cycles t, t+1, t+2; o_cdb_tag = 1, 2, 3 in cycles t+1..t+3.
- All three FUs held valid for 6 cycles → grant order 0,1,2,0,1,2; no FU starves.
- i_rob_head=14, CDB broadcasting tag 15 with mispredict; FU0 tag 1 (age 3), FU1 tag 14 (age 0) → FU0 ready and dropped; FU1 granted; next cycle o_cdb_tag=14, o_cdb_mispredict=0.
- rr_ptr=0; FU0 tag 2 no-mispredict, FU2 tag 5 mispredict → with CDB_ARB_BRANCH_PRIO_EN FU2 granted and rr_ptr=0; without it FU0 granted and rr_ptr=1.
- Single FU1 request held 3 cycles with payloads preg 7/8/9 → ready every cycle; o_cdb_preg 7, 8, 9 on consecutive cycles; o_cdb_valid then drops to 0.
